jk_bank_sequencer: RTL and testbench
====================================

# jk_bank_sequencer

Controller that sequences a bank of `WIDTH` internally instantiated JK flip-flop cells. Commands arrive over a valid/ready interface and are translated into per-cell J/K vectors:
- masked write
- masked toggle
- N-step synchronous binary count
- clear

It is the block that drives JK cells in the design. The J/K vectors are exported for observability.

## Interface
Parameters:
- `WIDTH`, 8, number of JK cells in the bank.
- `CNT_W`, 8, width of the COUNT step argument.

Ports:
- `CLK`  in  1  rising-edge clock; single clock domain.
- `RST`  in  1  synchronous, active-high reset.
- `CMD_VALID`  in  1  command present.
- `CMD_READY`  out  1  controller can accept a command.
- `CMD_OP`  in  2  00 WRITE, 01 TOGGLE, 10 COUNT, 11 CLEAR.
- `CMD_MASK`  in  WIDTH  per-bit enable for WRITE/TOGGLE; ignored for COUNT/CLEAR.
- `CMD_DATA`  in  WIDTH  write value for WRITE.
- `CMD_CNT`  in  CNT_W  step count for COUNT.
- `Q`  out  WIDTH  bank state (cell Q outputs).
- `J_OUT`  out  WIDTH  J vector currently driven into the cells.
- `K_OUT`  out  WIDTH  K vector currently driven into the cells.
- `BUSY`  out  1  a command is executing.
- `DONE`  out  1  one-cycle pulse: the last command's effect is visible on `Q`.

## Operation
- **Cells.** Each cell is a standard JK cell with no reset of its own:
  - 00 hold, 01 reset, 10 set, 11 toggle.
  - The controller only affects `Q` through J/K.
- **FSM states:** IDLE, APPLY, COUNT.
- **IDLE:**
  - J=K=0 (hold); `CMD_READY`=1 unless `RST`.
  - Accept on an edge with `CMD_VALID & CMD_READY`; latch op, mask, data, count.
- **APPLY (WRITE, TOGGLE, CLEAR):** one cycle, then IDLE.
  - WRITE: masked bit i gets J=`DATA[i]`, K=~`DATA[i]`; unmasked bits J=K=0.
  - TOGGLE: masked bits J=K=1; others 0.
  - CLEAR: J=0, K=all ones.
- **COUNT with N≥1:**
  - Stay in COUNT for exactly N cycles, with a remaining-count register decremented each edge.
  - J[i]=K[i]=AND(Q[i-1:0]); J[0]=K[0]=1. This is a synchronous binary up-count modulo 2^WIDTH, wrapping all-ones → 0.
  - Return to IDLE on the edge where remaining==1.
- **COUNT with N=0:** accepted straight back to IDLE; J=K=0; `Q` unchanged; DONE still pulses.
- **DONE:** registered; set on the edge that leaves APPLY/COUNT (or accepts COUNT 0); cleared next edge.
- **BUSY:** 1 in APPLY/COUNT, 0 otherwise.
- **Inputs when not ready:** commands while `CMD_READY`=0 are not accepted. The master holds `CMD_VALID` and fields stable until accepted.
- **Reset:**
  - While `RST`=1: J=0, K=all ones, so `Q`=0 after the first rising edge with `RST` high.
  - State←IDLE, remaining←0, `DONE`←0; `CMD_READY`=0, `BUSY`=0.
  - Reset mid-command aborts it with no DONE.
  - `Q` is X before the first reset edge.

## Timing
- Accept at edge t:
  - APPLY J/K driven during cycle t→t+1; `Q` updates at edge t+1.
  - `DONE`=1 and `CMD_READY`=1 in cycle t+1→t+2.
- Command issue rate: a new command can be accepted at edge t+2. Throughput is one single-step command per 2 cycles.
- COUNT N accepted at edge t:
  - `Q` increments at edges t+1 … t+N.
  - `DONE` high in cycle t+N→t+N+1.
- `J_OUT`/`K_OUT` are combinational from state, latched command and `Q`.
- `CMD_READY`, `BUSY`, `DONE`: `BUSY` and `CMD_READY` decode combinationally from state and `RST`; `DONE` is a register.
- Reset values: `DONE`=0, `BUSY`=0, `CMD_READY`=0 while `RST`=1, `Q`=0 one edge after `RST` asserted.

## Test plan
1. **Reset.** `RST`=1 for 2 cycles from unknown state.
   - `Q`=0x00, `J_OUT`=0x00, `K_OUT`=0xFF.
   - `CMD_READY`=0 during reset; 1 in the first cycle after deassertion; `DONE`=0.
2. **WRITE.** From `Q`=0xF0, WRITE mask 0x0F data 0xA5.
   - `J_OUT`=0x05 and `K_OUT`=0x0A in the apply cycle.
   - `Q`=0xF5 one edge later; `DONE` pulses once.
3. **TOGGLE.**
   - From 0xF5, TOGGLE mask 0xFF → `Q`=0x0A.
   - Then TOGGLE mask 0x81 → `Q`=0x8B.
   - Second command accepted in the first command's DONE cycle.
4. **COUNT.**
   - From 0xFE, COUNT 3 → `Q`=0xFF, 0x00, 0x01 on successive edges; `BUSY`=1 for 3 cycles; `DONE` after the third edge.
   - COUNT 0 → `DONE` next cycle, `Q` unchanged, `BUSY` never 1.
5. **Backpressure and abort.**
   - `CMD_VALID` held with CLEAR during COUNT 5: not accepted until `CMD_READY`; CLEAR then gives `Q`=0x00.
   - Separately, `RST` pulsed after 2 COUNT steps: `Q`=0x00, no `DONE`, FSM in IDLE.
6. **Wrap and masking.**
   - From 0xFF, COUNT 1 → 0x00.
   - WRITE mask 0x00 → `Q` unchanged, `DONE` still pulses.

Source files
------------

// File: rtl/jk_bank_sequencer_if.sv
// Command channel for jk_bank_sequencer: valid/ready handshake plus the
// op, mask, data and count fields that travel with it.
interface jk_bank_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_OP;
    logic [WIDTH-1:0] CMD_MASK;
    logic [WIDTH-1:0] CMD_DATA;
    logic [CNT_W-1:0] CMD_CNT;

    modport master (
        output CMD_VALID,
        output CMD_OP,
        output CMD_MASK,
        output CMD_DATA,
        output CMD_CNT,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_OP,
        input  CMD_MASK,
        input  CMD_DATA,
        input  CMD_CNT,
        output CMD_READY
    );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Sequencer for a bank of JK cells: turns WRITE/TOGGLE/COUNT/CLEAR commands
// into per-cell J/K vectors; the cells themselves carry no reset.
module jk_cell (
    input  logic clk,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk) begin
        case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
        endcase
    end
endmodule

module jk_bank_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    jk_bank_sequencer_if.slave  cmd,
    output logic [WIDTH-1:0]    Q,
    output logic [WIDTH-1:0]    J_OUT,
    output logic [WIDTH-1:0]    K_OUT,
    output logic                BUSY,
    output logic                DONE
);

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_TOGGLE = 2'b01,
        OP_COUNT  = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        COUNT
    } state_e;

    state_e           state;
    state_e           state_next;
    op_e              op_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] remaining_next;
    logic             done_next;
    logic             accept;
    logic             carry;

    assign cmd.CMD_READY = (state == IDLE) && !RST;
    assign BUSY          = (state != IDLE) && !RST;
    assign accept        = cmd.CMD_VALID && cmd.CMD_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            remaining <= '0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            DONE      <= done_next;
        end
    end

    // Command fields only matter while a command executes, so no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            op_q   <= op_e'(cmd.CMD_OP);
            mask_q <= cmd.CMD_MASK;
            data_q <= cmd.CMD_DATA;
        end
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op_e'(cmd.CMD_OP) == OP_COUNT) begin
                        if (cmd.CMD_CNT == '0) begin
                            done_next = 1'b1;
                        end else begin
                            state_next     = COUNT;
                            remaining_next = cmd.CMD_CNT;
                        end
                    end else begin
                        state_next = APPLY;
                    end
                end
            end
            APPLY: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            COUNT: begin
                remaining_next = remaining - 1'b1;
                if (remaining <= CNT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        J_OUT = '0;
        K_OUT = '0;
        carry = 1'b1;
        if (RST) begin
            K_OUT = '1;
        end else begin
            case (state)
                APPLY: begin
                    case (op_q)
                        OP_WRITE: begin
                            J_OUT = mask_q & data_q;
                            K_OUT = mask_q & ~data_q;
                        end
                        OP_TOGGLE: begin
                            J_OUT = mask_q;
                            K_OUT = mask_q;
                        end
                        OP_CLEAR: K_OUT = '1;
                        default: ;
                    endcase
                end
                COUNT: begin
                    // Ripple carry: a cell toggles when every lower cell is 1.
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        J_OUT[i] = carry;
                        K_OUT[i] = carry;
                        carry    = carry & Q[i];
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk (CLK),
            .j   (J_OUT[g]),
            .k   (K_OUT[g]),
            .q   (Q[g])
        );
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Randomized and directed bench for jk_bank_sequencer against a behavioural
// model of the bank value and the J/K vectors each command implies.
module tb_jk_bank_sequencer;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] J_OUT;
    logic [WIDTH-1:0] K_OUT;
    logic             BUSY;
    logic             DONE;

    int               checks = 0;
    int               errors = 0;
    logic [7:0]       model_q;

    always #5 CLK = ~CLK;

    jk_bank_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .cmd   (bus),
        .Q     (Q),
        .J_OUT (J_OUT),
        .K_OUT (K_OUT),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One idle cycle: everything quiet, bank holds.
    task automatic idle_cycle();
        @(negedge CLK);
        check("idle_done", DONE, 0);
        check("idle_busy", BUSY, 0);
        check("idle_ready", bus.CMD_READY, 1);
        check("idle_j", J_OUT, 8'h00);
        check("idle_k", K_OUT, 8'h00);
        check("idle_q", Q, model_q);
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic exec(input logic [1:0] op, input logic [7:0] m, input logic [7:0] d,
                        input logic [7:0] n, input bit hold_clear);
        int         wait_n = 0;
        logic [7:0] inc;
        bus.CMD_OP    = op;
        bus.CMD_MASK  = m;
        bus.CMD_DATA  = d;
        bus.CMD_CNT   = n;
        bus.CMD_VALID = 1'b1;
        while (bus.CMD_READY !== 1'b1 && wait_n < 200) begin
            @(negedge CLK);
            wait_n++;
        end
        check("ready_seen", bus.CMD_READY, 1);
        @(posedge CLK);
        #1;
        if (hold_clear) begin
            bus.CMD_OP   = 2'b11;
            bus.CMD_MASK = 8'($urandom);
        end else begin
            bus.CMD_VALID = 1'b0;
        end
        if (op == 2'b10) begin
            for (int s = 0; s < int'(n); s++) begin
                @(negedge CLK);
                inc = model_q + 8'd1;
                check("cnt_busy", BUSY, 1);
                check("cnt_ready", bus.CMD_READY, 0);
                check("cnt_done", DONE, 0);
                check("cnt_q", Q, model_q);
                check("cnt_j", J_OUT, model_q ^ inc);
                check("cnt_k", K_OUT, model_q ^ inc);
                model_q = inc;
            end
            @(negedge CLK);
            check("cnt_end_q", Q, model_q);
            check("cnt_end_done", DONE, 1);
            check("cnt_end_busy", BUSY, 0);
            check("cnt_end_ready", bus.CMD_READY, 1);
            if (n == 8'd0) begin
                check("cnt0_j", J_OUT, 8'h00);
                check("cnt0_k", K_OUT, 8'h00);
            end
        end else begin
            @(negedge CLK);
            check("apl_busy", BUSY, 1);
            check("apl_ready", bus.CMD_READY, 0);
            check("apl_done", DONE, 0);
            case (op)
                2'b00: begin
                    check("wr_j", J_OUT, d & m);
                    check("wr_k", K_OUT, ~d & m);
                    model_q = (model_q & ~m) | (d & m);
                end
                2'b01: begin
                    check("tg_j", J_OUT, m);
                    check("tg_k", K_OUT, m);
                    model_q = model_q ^ m;
                end
                default: begin
                    check("clr_j", J_OUT, 8'h00);
                    check("clr_k", K_OUT, 8'hFF);
                    model_q = 8'h00;
                end
            endcase
            @(negedge CLK);
            check("apl_end_q", Q, model_q);
            check("apl_end_done", DONE, 1);
            check("apl_end_busy", BUSY, 0);
            check("apl_end_ready", bus.CMD_READY, 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST           = 1'b1;
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP    = 2'b00;
        bus.CMD_MASK  = '0;
        bus.CMD_DATA  = '0;
        bus.CMD_CNT   = '0;
        model_q       = 8'h00;

        // Reset from unknown state
        @(negedge CLK);
        check("rst_ready", bus.CMD_READY, 0);
        check("rst_busy", BUSY, 0);
        check("rst_j", J_OUT, 8'h00);
        check("rst_k", K_OUT, 8'hFF);
        @(negedge CLK);
        check("rst_q", Q, 8'h00);
        check("rst_done", DONE, 0);
        check("rst_ready2", bus.CMD_READY, 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("post_rst_ready", bus.CMD_READY, 1);
        check("post_rst_done", DONE, 0);
        check("post_rst_q", Q, 8'h00);

        // WRITE into 0xF0 then masked WRITE 0x0F/0xA5
        exec(2'b00, 8'hFF, 8'hF0, 8'd0, 1'b0);
        exec(2'b00, 8'h0F, 8'hA5, 8'd0, 1'b0);
        check("wr_result", Q, 8'hF5);
        idle_cycle();

        // Back-to-back toggles
        exec(2'b01, 8'hFF, 8'h00, 8'd0, 1'b0);
        check("tg1_result", Q, 8'h0A);
        exec(2'b01, 8'h81, 8'h00, 8'd0, 1'b0);
        check("tg2_result", Q, 8'h8B);
        idle_cycle();

        // COUNT 3 across the wrap, then COUNT 0
        exec(2'b00, 8'hFF, 8'hFE, 8'd0, 1'b0);
        exec(2'b10, 8'h00, 8'h00, 8'd3, 1'b0);
        check("cnt3_result", Q, 8'h01);
        idle_cycle();
        exec(2'b10, 8'h00, 8'h00, 8'd0, 1'b0);
        check("cnt0_result", Q, 8'h01);
        idle_cycle();

        // CLEAR held under backpressure during COUNT 5
        exec(2'b10, 8'h00, 8'h00, 8'd5, 1'b1);
        check("bp_before_clear", Q, 8'h06);
        exec(2'b11, bus.CMD_MASK, 8'h00, 8'd0, 1'b0);
        check("bp_clear_result", Q, 8'h00);
        idle_cycle();

        // Reset after two COUNT steps
        bus.CMD_OP    = 2'b10;
        bus.CMD_CNT   = 8'd5;
        bus.CMD_VALID = 1'b1;
        @(posedge CLK);
        #1 bus.CMD_VALID = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("abort_q_pre", Q, 8'h02);
        check("abort_busy_pre", BUSY, 1);
        RST = 1'b1;
        #1;
        check("abort_busy", BUSY, 0);
        check("abort_ready", bus.CMD_READY, 0);
        check("abort_k", K_OUT, 8'hFF);
        @(posedge CLK);
        #1 RST = 1'b0;
        model_q = 8'h00;
        @(negedge CLK);
        check("abort_q", Q, 8'h00);
        check("abort_done", DONE, 0);
        check("abort_ready_after", bus.CMD_READY, 1);
        idle_cycle();

        // Wrap and empty mask
        exec(2'b00, 8'hFF, 8'hFF, 8'd0, 1'b0);
        exec(2'b10, 8'h00, 8'h00, 8'd1, 1'b0);
        check("wrap_result", Q, 8'h00);
        exec(2'b00, 8'h00, 8'h5A, 8'd0, 1'b0);
        check("nomask_result", Q, 8'h00);
        idle_cycle();

        // Random command stream
        for (int i = 0; i < 60; i++) begin
            exec(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 8'($urandom_range(0, 6)), 1'b0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
